pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 74 +++++++
 tb/tb_pwm_multi.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: Wishbone-programmed multi-channel PWM; shared counter/period, per-channel duty, wrap-synchronous reload. Ports: clock/reset, wb_* slave, pwm_o[CHANNELS], wrap_o.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8
) (
  input logic clock,
  input logic reset,
  input logic wb_cyc_i,
  input logic wb_stb_i,
  input logic wb_we_i,
  input logic [4:0] wb_adr_i,
  input logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic wb_ack_o,
  output logic [CHANNELS-1:0] pwm_o,
  output logic wrap_o
);
  logic [1:0] ctrl;
  logic [WIDTH-1:0] period_s, period_a, cnt;
  logic [WIDTH-1:0] duty_s [CHANNELS];
  logic [WIDTH-1:0] duty_a [CHANNELS];
  logic req, en, inv, wrap, reload;
  logic [31:0] rdata;
  logic [CHANNELS-1:0] raw;
  logic unused_bits;
  assign unused_bits = &{1'b0, wb_dat_i[31:WIDTH]};
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign en = ctrl[0];
  assign inv = ctrl[1];
  assign wrap = en & (cnt == period_a);
  // disabled: actives follow shadows every cycle so enabling starts from current shadows
  assign reload = wrap | ~en;
  always_comb begin
    rdata = wb_adr_i == 5'd0 ? {30'd0, ctrl} : wb_adr_i == 5'd1 ? 32'(period_s) : 32'd0;
    for (int n = 0; n < CHANNELS; n++)
      if (wb_adr_i == 5'(n + 2)) rdata = 32'(duty_s[n]);
  end
  always_comb begin
    raw = '0;
    for (int n = 0; n < CHANNELS; n++) raw[n] = cnt < duty_a[n];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl <= 2'd0;
      period_s <= '1;
      period_a <= '1;
      cnt <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        duty_s[n] <= '0;
        duty_a[n] <= '0;
      end
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      pwm_o <= '0;
      wrap_o <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rdata : 32'd0;
      if (req && wb_we_i) begin
        if (wb_adr_i == 5'd0) ctrl <= wb_dat_i[1:0];
        if (wb_adr_i == 5'd1) period_s <= wb_dat_i[WIDTH-1:0];
        for (int n = 0; n < CHANNELS; n++)
          if (wb_adr_i == 5'(n + 2)) duty_s[n] <= wb_dat_i[WIDTH-1:0];
      end
      cnt <= reload ? '0 : cnt + WIDTH'(1);
      if (reload) begin
        period_a <= period_s;
        duty_a <= duty_s;
      end
      wrap_o <= wrap;
      pwm_o <= en ? raw ^ {CHANNELS{inv}} : {CHANNELS{inv}};
    end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed plus randomized checks of pwm_multi against a cycle-level reference model.
module tb_pwm_multi;
  logic clock = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [4:0] adr = 0;
  logic [31:0] dat = 0, dat_o;
  logic ack, wrap;
  logic [3:0] pwm;
  int tests = 0, fails = 0;
  int m_ctrl, m_per_s, m_per_a, m_cnt;
  int m_duty_s [4];
  int m_duty_a [4];
  logic [3:0] e_pwm;
  logic e_wrap, e_ack, e_rd;
  logic [31:0] e_dat, rd;
  int acc [4];
  int acc_wrap;
  pwm_multi dut (
    .clock(clock), .reset(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .pwm_o(pwm), .wrap_o(wrap)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic req, en, inv;
    @(posedge clock);
    if (rst) begin
      m_ctrl = 0; m_per_s = 255; m_per_a = 255; m_cnt = 0;
      for (int n = 0; n < 4; n++) begin m_duty_s[n] = 0; m_duty_a[n] = 0; end
      e_pwm = 0; e_wrap = 0; e_ack = 0; e_rd = 0; e_dat = 0;
    end else begin
      en = m_ctrl[0]; inv = m_ctrl[1];
      req = cyc && stb && !e_ack;
      e_wrap = en && m_cnt == m_per_a;
      for (int n = 0; n < 4; n++) e_pwm[n] = en ? ((m_cnt < m_duty_a[n]) ^ inv) : inv;
      e_dat = adr == 0 ? 32'(m_ctrl) : adr == 1 ? 32'(m_per_s) :
              (adr >= 2 && adr < 6) ? 32'(m_duty_s[adr - 2]) : 32'd0;
      e_ack = req; e_rd = req && !we;
      if (!en || e_wrap) begin
        m_per_a = m_per_s; m_duty_a = m_duty_s; m_cnt = 0;
      end else m_cnt++;
      if (req && we) begin
        if (adr == 0) m_ctrl = int'(dat[1:0]);
        if (adr == 1) m_per_s = int'(dat[7:0]);
        if (adr >= 2 && adr < 6) m_duty_s[adr - 2] = int'(dat[7:0]);
      end
    end
    #1;
    chk("pwm", 32'(pwm), 32'(e_pwm));
    chk("wrap", 32'(wrap), 32'(e_wrap));
    chk("ack", 32'(ack), 32'(e_ack));
    if (e_ack && e_rd) chk("rdata", dat_o, e_dat);
    for (int n = 0; n < 4; n++) acc[n] += int'(pwm[n]);
    acc_wrap += int'(wrap);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask
  task automatic clr();
    for (int n = 0; n < 4; n++) acc[n] = 0;
    acc_wrap = 0;
  endtask
  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    cyc = 1; stb = 1; we = 1; adr = a; dat = d;
    tick();
    cyc = 0; stb = 0; we = 0;
    tick();
  endtask
  task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
    cyc = 1; stb = 1; we = 0; adr = a;
    tick();
    d = dat_o;
    cyc = 0; stb = 0;
    tick();
  endtask
  task automatic wait_wrap();
    for (int i = 0; i < 300 && !wrap; i++) tick();
    chk("wrap_seen", 32'(wrap), 32'd1);
  endtask
  initial begin
    clr();
    idle(3);
    chk("reset_pwm", 32'(pwm), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_dat", dat_o, 32'd0);
    rst = 0;
    wb_read(1, rd); chk("reset_period", rd, 32'd255);
    wb_read(2, rd); chk("reset_duty0", rd, 32'd0);
    wb_write(1, 9); wb_write(2, 3); wb_write(0, 1);
    idle(5); clr(); idle(10);
    chk("def_ch0_high", acc[0], 3);
    chk("def_wraps", acc_wrap, 1);
    wb_write(3, 0); wb_write(4, 10); wb_write(5, 9);
    idle(12); clr(); idle(10);
    chk("ch1_low", acc[1], 0);
    chk("ch2_high", acc[2], 10);
    chk("ch3_high", acc[3], 9);
    wait_wrap();
    clr(); idle(2); wb_write(2, 7); idle(6);
    chk("shadow_old_period", acc[0], 3);
    clr(); idle(10);
    chk("shadow_new_period", acc[0], 7);
    wb_write(2, 3); idle(25); wb_write(0, 3);
    idle(12); clr(); idle(10);
    chk("invert_ch0_high", acc[0], 7);
    wb_write(0, 2); idle(1);
    chk("disabled_invert", 32'(pwm), 32'hf);
    wb_write(1, 0); wb_write(0, 1);
    idle(2); clr(); idle(5);
    chk("period0_wraps", acc_wrap, 5);
    wb_write(1, 9); idle(2);
    wb_read(1, rd); chk("read_period", rd, 32'd9);
    wb_read(31, rd); chk("read_unmapped", rd, 32'd0);
    cyc = 1; stb = 1; we = 0; adr = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("held_ack", 32'(ack), 32'(i % 2 == 0));
    end
    cyc = 0; stb = 0;
    idle(12);
    for (int i = 0; i < 30 && !pwm[0]; i++) tick();
    chk("high_phase", 32'(pwm[0]), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("midreset_pwm", 32'(pwm), 32'd0);
    chk("midreset_wrap", 32'(wrap), 32'd0);
    chk("midreset_ack", 32'(ack), 32'd0);
    wb_read(1, rd); chk("midreset_period", rd, 32'd255);
    wb_read(0, rd); chk("midreset_ctrl", rd, 32'd0);
    for (int it = 0; it < 1500; it++) begin
      int r;
      logic [4:0] a;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1; tick(); rst = 0;
      end else if (r < 4) begin
        a = 5'($urandom_range(0, 7));
        if (a == 0) wb_write(a, $urandom_range(0, 7) == 0 ? $urandom : ($urandom | 1));
        else if (a == 1) wb_write(a, $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 12)));
        else wb_write(a, ($urandom & 32'hffffff00) | 32'($urandom_range(0, 14)));
      end else if (r < 6) begin
        wb_read(5'($urandom_range(0, 31)), rd);
      end else if (r == 6) begin
        cyc = 1; stb = 1; we = 0; adr = 5'($urandom_range(0, 7));
        idle(3);
        cyc = 0; stb = 0;
        tick();
      end else tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
